gato_move_sequencer: RTL and testbench

GATO_MOVE_SEQUENCER -- requirements
Module: gato_move_sequencer

---
 rtl/gato_pkg.sv | 40 ++++
 rtl/gato_move_sequencer_if.sv | 43 ++++
 rtl/gato_cursor.sv | 49 ++++
 rtl/gato_move_sequencer.sv | 161 ++++++++++++++++
 tb/tb_gato_move_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gato_pkg.sv
// gato_pkg -- shared definitions for the tic-tac-toe move sequencer.
//   state_e     : FSM state codes (also driven out on the 3-bit state port)
//   cell_e      : board cell codes as stored in the game register
//   CENTER_CELL : cursor position after reset
//   BOARD_W     : width of the packed 9-cell board
//   cell_at()   : extracts one cell code from the packed board
package gato_pkg;

   typedef enum logic [2:0] {
      P1_SEL = 3'd0,
      P1_WR  = 3'd1,
      P1_CHK = 3'd2,
      P2_SEL = 3'd3,
      P2_WR  = 3'd4,
      P2_CHK = 3'd5,
      DONE   = 3'd6
   } state_e;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      P1    = 2'b01,
      P2    = 2'b10
   } cell_e;

   localparam logic [3:0]  CENTER_CELL = 4'd4;
   localparam logic [3:0]  LAST_CELL   = 4'd8;
   localparam int unsigned BOARD_W     = 18;

   // Out-of-range indices read as an illegal code so they never look empty.
   function automatic logic [1:0] cell_at(input logic [BOARD_W-1:0] board,
                                          input logic [3:0]         idx);
      logic [1:0] v;
      v = 2'b11;
      for (int unsigned k = 0; k < 9; k++) begin
         if (idx == 4'(k)) v = board[2*k +: 2];
      end
      return v;
   endfunction

endpackage

// File: rtl/gato_move_sequencer_if.sv
// gato_move_sequencer_if -- player buttons, board/verifier inputs and the
// sequencer's outputs bundled together.
//   master : the sequencer side (consumes buttons/board/verifier, drives
//            write strobe, check request, cursor, turn and status outputs)
//   slave  : the environment side (game register, verifier, button logic)
interface gato_move_sequencer_if;
   import gato_pkg::*;

   logic               btn_up;
   logic               btn_down;
   logic               btn_left;
   logic               btn_right;
   logic               btn_select;
   logic [BOARD_W-1:0] cell_state;
   logic               check_done;
   logic               game_over;

   logic               wr_en;
   logic [3:0]         wr_cell;
   logic [1:0]         wr_value;
   logic               check_req;
   logic [3:0]         cursor;
   logic               turn_p1;
   logic               turn_p2;
   logic [2:0]         state;
   logic               reject;
   logic               timeout;

   modport master (
      input  btn_up, btn_down, btn_left, btn_right, btn_select,
      input  cell_state, check_done, game_over,
      output wr_en, wr_cell, wr_value, check_req, cursor,
      output turn_p1, turn_p2, state, reject, timeout
   );

   modport slave (
      output btn_up, btn_down, btn_left, btn_right, btn_select,
      output cell_state, check_done, game_over,
      input  wr_en, wr_cell, wr_value, check_req, cursor,
      input  turn_p1, turn_p2, state, reject, timeout
   );

endinterface

// File: rtl/gato_cursor.sv
// gato_cursor -- next-cursor computation for the 3x3 board.
//   cur_i         : current cursor, 0..8 row-major
//   btn_*_i       : one-cycle button pulses
//   nxt_o         : cursor after applying at most one button
// Priority is select > up > down > left > right; select never moves the
// cursor. Moves wrap within the same column (up/down) or row (left/right).
module gato_cursor
   import gato_pkg::*;
(
   input  logic [3:0] cur_i,
   input  logic       btn_select_i,
   input  logic       btn_up_i,
   input  logic       btn_down_i,
   input  logic       btn_left_i,
   input  logic       btn_right_i,
   output logic [3:0] nxt_o
);

   logic [3:0] row_base;
   logic       at_top;
   logic       at_bottom;
   logic       at_left;
   logic       at_right;

   always_comb begin
      at_top    = cur_i < 4'd3;
      at_bottom = cur_i >= 4'd6;
      // first cell of the current row; column tests are relative to it
      row_base  = at_bottom ? 4'd6 : (at_top ? 4'd0 : 4'd3);
      at_left   = cur_i == row_base;
      at_right  = cur_i == (row_base + 4'd2);

      nxt_o = cur_i;
      if (cur_i > LAST_CELL) begin
         nxt_o = CENTER_CELL;
      end else if (btn_select_i) begin
         nxt_o = cur_i;
      end else if (btn_up_i) begin
         nxt_o = at_top ? cur_i + 4'd6 : cur_i - 4'd3;
      end else if (btn_down_i) begin
         nxt_o = at_bottom ? cur_i - 4'd6 : cur_i + 4'd3;
      end else if (btn_left_i) begin
         nxt_o = at_left ? cur_i + 4'd2 : cur_i - 4'd1;
      end else if (btn_right_i) begin
         nxt_o = at_right ? cur_i - 4'd2 : cur_i + 4'd1;
      end
   end

endmodule

// File: rtl/gato_move_sequencer.sv
// gato_move_sequencer -- turn/move FSM for a two-player tic-tac-toe game.
//   clk, reset : single clock, asynchronous active-high reset
//   bus        : gato_move_sequencer_if.master
//                in : buttons, cell_state board, check_done/game_over
//                out: wr_en/wr_cell/wr_value board write, check_req,
//                     cursor, turn_p1/turn_p2, state, reject, timeout
//   TIMEOUT_CYCLES : cycles a player may idle in a select state (2..65535)
// Optional feature: define GATO_TURN_TIMEOUT_EN to forfeit a turn after
// TIMEOUT_CYCLES-1 idle cycles; otherwise timeout is tied low.
// All outputs are registered; their values follow the next state.
module gato_move_sequencer
   import gato_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic                   clk,
   input  logic                   reset,
   gato_move_sequencer_if.master  bus
);

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 2..65535");
   end

   state_e     state_q, state_d;
   logic [3:0] cursor_q, cursor_d;
   logic [3:0] cursor_nxt;
   logic       wr_en_q, wr_en_d;
   logic [3:0] wr_cell_q, wr_cell_d;
   logic [1:0] wr_value_q, wr_value_d;
   logic       check_req_q, check_req_d;
   logic       turn_p1_q, turn_p1_d;
   logic       turn_p2_q, turn_p2_d;
   logic       reject_q, reject_d;
   logic       in_sel;
   logic       is_p1;
   logic       cell_free;

`ifdef GATO_TURN_TIMEOUT_EN
   localparam logic [15:0] EXPIRE_AT = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] cnt_q, cnt_d;
   logic        timeout_q, timeout_d;
   logic        expire;
`endif

   gato_cursor u_cursor (
      .cur_i        (cursor_q),
      .btn_select_i (bus.btn_select),
      .btn_up_i     (bus.btn_up),
      .btn_down_i   (bus.btn_down),
      .btn_left_i   (bus.btn_left),
      .btn_right_i  (bus.btn_right),
      .nxt_o        (cursor_nxt)
   );

   always_comb begin
      in_sel    = (state_q == P1_SEL) || (state_q == P2_SEL);
      is_p1     = state_q == P1_SEL;
      cell_free = cell_at(bus.cell_state, cursor_q) == EMPTY;

      state_d    = state_q;
      cursor_d   = cursor_q;
      wr_en_d    = 1'b0;
      wr_cell_d  = '0;
      wr_value_d = '0;
      reject_d   = 1'b0;
`ifdef GATO_TURN_TIMEOUT_EN
      timeout_d  = 1'b0;
      // the counter reaches TIMEOUT_CYCLES-1 on this edge
      expire     = in_sel && ((cnt_q + 16'd1) == EXPIRE_AT);
`endif

      case (state_q)
         P1_SEL, P2_SEL: begin
            if (bus.btn_select && cell_free) begin
               // an accepted select wins over a simultaneous expiry
               state_d    = is_p1 ? P1_WR : P2_WR;
               wr_en_d    = 1'b1;
               wr_cell_d  = cursor_q;
               wr_value_d = is_p1 ? P1 : P2;
            end else begin
               reject_d = bus.btn_select;
               cursor_d = cursor_nxt;
`ifdef GATO_TURN_TIMEOUT_EN
               if (expire) begin
                  timeout_d = 1'b1;
                  state_d   = is_p1 ? P2_SEL : P1_SEL;
               end
`endif
            end
         end
         P1_WR:  state_d = P1_CHK;
         P2_WR:  state_d = P2_CHK;
         P1_CHK: if (bus.check_done) state_d = bus.game_over ? DONE : P2_SEL;
         P2_CHK: if (bus.check_done) state_d = bus.game_over ? DONE : P1_SEL;
         DONE:   state_d = DONE;
         default: state_d = P1_SEL;
      endcase

      check_req_d = (state_d == P1_CHK) || (state_d == P2_CHK);
      turn_p1_d   = state_d inside {P1_SEL, P1_WR, P1_CHK};
      turn_p2_d   = state_d inside {P2_SEL, P2_WR, P2_CHK};

`ifdef GATO_TURN_TIMEOUT_EN
      // cleared on entry to a select state (including a forfeit hand-over)
      if ((state_d == P1_SEL) || (state_d == P2_SEL)) begin
         cnt_d = (state_d == state_q) ? cnt_q + 16'd1 : '0;
      end else begin
         cnt_d = '0;
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= P1_SEL;
         cursor_q    <= CENTER_CELL;
         wr_en_q     <= 1'b0;
         wr_cell_q   <= '0;
         wr_value_q  <= '0;
         check_req_q <= 1'b0;
         turn_p1_q   <= 1'b1;
         turn_p2_q   <= 1'b0;
         reject_q    <= 1'b0;
`ifdef GATO_TURN_TIMEOUT_EN
         cnt_q       <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cursor_q    <= cursor_d;
         wr_en_q     <= wr_en_d;
         wr_cell_q   <= wr_cell_d;
         wr_value_q  <= wr_value_d;
         check_req_q <= check_req_d;
         turn_p1_q   <= turn_p1_d;
         turn_p2_q   <= turn_p2_d;
         reject_q    <= reject_d;
`ifdef GATO_TURN_TIMEOUT_EN
         cnt_q       <= cnt_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign bus.state     = state_q;
   assign bus.cursor    = cursor_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_cell   = wr_cell_q;
   assign bus.wr_value  = wr_value_q;
   assign bus.check_req = check_req_q;
   assign bus.turn_p1   = turn_p1_q;
   assign bus.turn_p2   = turn_p2_q;
   assign bus.reject    = reject_q;
`ifdef GATO_TURN_TIMEOUT_EN
   assign bus.timeout   = timeout_q;
`else
   assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_gato_move_sequencer.sv
// tb_gato_move_sequencer -- directed and randomized checks of the move
// sequencer against a row/column game model kept in this file.
module tb_gato_move_sequencer;

   localparam int unsigned T = 8;

   logic clk = 1'b0;
   logic reset;

   gato_move_sequencer_if bus ();

   gato_move_sequencer #(.TIMEOUT_CYCLES(T)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // game model: board contents, cursor as row/col, whose turn, phase
   int board[9];
   int m_row, m_col, m_player, m_phase, m_idle;
   bit m_done;
   int e_wr, e_cell, e_val, e_rej, e_to;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [17:0] pack_board();
      logic [17:0] b;
      for (int k = 0; k < 9; k++) b[2*k +: 2] = 2'(board[k]);
      return b;
   endfunction

   function automatic bit board_full();
      for (int k = 0; k < 9; k++) if (board[k] == 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_row = 1; m_col = 1; m_player = 1; m_phase = 0; m_idle = 0; m_done = 1'b0;
      e_wr = 0; e_cell = 0; e_val = 0; e_rej = 0; e_to = 0;
      for (int k = 0; k < 9; k++) board[k] = 0;
   endtask

   // advances the model by one clock edge using the inputs now applied
   task automatic model_step();
      e_wr = 0; e_cell = 0; e_val = 0; e_rej = 0; e_to = 0;
      if (m_done) return;
      if (m_phase == 0) begin
         int c;
         bit acc;
         c = m_row * 3 + m_col;
         acc = 1'b0;
         if (bus.btn_select) begin
            if (board[c] == 0) begin
               acc = 1'b1; e_wr = 1; e_cell = c; e_val = m_player;
               board[c] = m_player; m_phase = 1; m_idle = 0;
            end else e_rej = 1;
         end else if (bus.btn_up)    m_row = (m_row + 2) % 3;
         else if (bus.btn_down)      m_row = (m_row + 1) % 3;
         else if (bus.btn_left)      m_col = (m_col + 2) % 3;
         else if (bus.btn_right)     m_col = (m_col + 1) % 3;
`ifdef GATO_TURN_TIMEOUT_EN
         if (!acc) begin
            m_idle++;
            if (m_idle == int'(T) - 1) begin
               e_to = 1; m_player = 3 - m_player; m_idle = 0;
            end
         end
`else
         if (acc) m_idle = 0;
`endif
      end else if (m_phase == 1) begin
         m_phase = 2;
      end else if (bus.check_done) begin
         if (bus.game_over) m_done = 1'b1;
         else begin m_player = 3 - m_player; m_phase = 0; m_idle = 0; end
      end
   endtask

   task automatic check_all(input string tag);
      int es;
      es = m_done ? 6 : (m_player - 1) * 3 + m_phase;
      check({tag, ":state"},     bus.state,     es);
      check({tag, ":cursor"},    bus.cursor,    m_row * 3 + m_col);
      check({tag, ":turn_p1"},   bus.turn_p1,   (!m_done && m_player == 1) ? 1 : 0);
      check({tag, ":turn_p2"},   bus.turn_p2,   (!m_done && m_player == 2) ? 1 : 0);
      check({tag, ":check_req"}, bus.check_req, (!m_done && m_phase == 2) ? 1 : 0);
      check({tag, ":wr_en"},     bus.wr_en,     e_wr);
      if (e_wr != 0) begin
         check({tag, ":wr_cell"},  bus.wr_cell,  e_cell);
         check({tag, ":wr_value"}, bus.wr_value, e_val);
      end
      check({tag, ":reject"},    bus.reject,    e_rej);
      check({tag, ":timeout"},   bus.timeout,   e_to);
   endtask

   task automatic clear_inputs();
      bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_left = 1'b0;
      bus.btn_right = 1'b0; bus.btn_select = 1'b0;
      bus.check_done = 1'b0; bus.game_over = 1'b0;
   endtask

   task automatic cycle(input string tag);
      model_step();
      @(posedge clk);
      #1;
      clear_inputs();
      bus.cell_state = pack_board();
      check_all(tag);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      model_reset();
      bus.cell_state = pack_board();
      @(posedge clk);
      #1;
      check_all("rst_hold");
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      model_reset();
      bus.cell_state = pack_board();
      repeat (2) @(posedge clk);
      #1;
      check_all("in_reset");
      check("rst_wr_cell",  bus.wr_cell,  0);
      check("rst_wr_value", bus.wr_value, 0);
      reset = 1'b0;

      // first move of player 1 at the centre
      check("start_cursor", bus.cursor, 4);
      check("start_state",  bus.state,  0);
      bus.btn_select = 1'b1;
      cycle("p1_sel");
      check("p1_wr_en",    bus.wr_en,    1);
      check("p1_wr_cell",  bus.wr_cell,  4);
      check("p1_wr_value", bus.wr_value, 1);
      cycle("p1_wr");
      check("p1_check_req", bus.check_req, 1);
      repeat (3) cycle("p1_chk_wait");
      bus.check_done = 1'b1;
      cycle("p1_chk_done");
      check("p2_state",  bus.state,   3);
      check("p2_turn",   bus.turn_p2, 1);
      check("p2_cursor", bus.cursor,  4);

      // player 2 selects the occupied centre
      bus.btn_select = 1'b1;
      cycle("p2_reject");
      check("reject_pulse", bus.reject, 1);
      check("reject_no_wr", bus.wr_en,  0);
      check("reject_state", bus.state,  3);
      cycle("reject_clear");
      check("reject_gone", bus.reject, 0);

      // cursor wrap and priority
      bus.btn_up = 1'b1;   cycle("mv_up");
      bus.btn_left = 1'b1; cycle("mv_left");
      check("cursor_0", bus.cursor, 0);
      bus.btn_up = 1'b1;   cycle("wrap_up");
      check("cursor_6", bus.cursor, 6);
      bus.btn_left = 1'b1; cycle("wrap_left");
      check("cursor_8", bus.cursor, 8);
      bus.btn_up = 1'b1; bus.btn_right = 1'b1; cycle("up_over_right");
      check("cursor_5", bus.cursor, 5);
      bus.btn_down = 1'b1; bus.btn_down = 1'b1; cycle("mv_down");
      bus.btn_right = 1'b1; cycle("wrap_right");

      // game runs to DONE, then buttons are ignored
      do_reset();
      bus.btn_select = 1'b1; cycle("g_p1_sel");
      cycle("g_p1_wr");
      bus.check_done = 1'b1; cycle("g_p1_chk");
      bus.btn_right = 1'b1;  cycle("g_p2_right");
      bus.btn_select = 1'b1; cycle("g_p2_sel");
      check("g_p2_value", bus.wr_value, 2);
      cycle("g_p2_wr");
      bus.check_done = 1'b1; bus.game_over = 1'b1; cycle("g_over");
      check("done_state", bus.state,   6);
      check("done_turn1", bus.turn_p1, 0);
      check("done_turn2", bus.turn_p2, 0);
      for (int i = 0; i < 4; i++) begin
         bus.btn_select = 1'b1; bus.btn_up = 1'b1; bus.btn_left = (i % 2) == 0;
         cycle("done_ignore");
      end
      check("done_hold", bus.state, 6);

      // asynchronous reset in P2_CHK
      do_reset();
      bus.btn_select = 1'b1; cycle("a_p1_sel");
      cycle("a_p1_wr");
      bus.check_done = 1'b1; cycle("a_p1_chk");
      bus.btn_right = 1'b1;  cycle("a_p2_right");
      bus.btn_select = 1'b1; cycle("a_p2_sel");
      cycle("a_p2_wr");
      check("a_p2_chk_req", bus.check_req, 1);
      cycle("a_p2_chk_wait");
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check("async_check_req", bus.check_req, 0);
      check("async_state",     bus.state,     0);
      check("async_cursor",    bus.cursor,    4);
      check("async_wr_en",     bus.wr_en,     0);
      bus.cell_state = pack_board();
      @(posedge clk);
      #1;
      check_all("async_hold");
      reset = 1'b0;

`ifdef GATO_TURN_TIMEOUT_EN
      // idle player 1 forfeits; player 2 selects exactly at expiry
      do_reset();
      for (int i = 0; i < int'(T) - 2; i++) begin
         cycle("to_idle");
         check("to_none", bus.timeout, 0);
      end
      cycle("to_fire");
      check("to_pulse",   bus.timeout, 1);
      check("to_state",   bus.state,   3);
      check("to_no_wr",   bus.wr_en,   0);
      cycle("to_clear");
      check("to_pulse_end", bus.timeout, 0);
      for (int i = 0; i < int'(T) - 3; i++) cycle("to_idle2");
      bus.btn_select = 1'b1;
      cycle("to_sel_wins");
      check("to_sel_wr",    bus.wr_en,   1);
      check("to_sel_no_to", bus.timeout, 0);
      check("to_sel_state", bus.state,   4);
`else
      do_reset();
      for (int i = 0; i < 40; i++) cycle("no_timeout_idle");
      check("idle_state", bus.state, 0);
`endif

      // randomized play
      do_reset();
      for (int i = 0; i < 800; i++) begin
         if (m_done || board_full() || $urandom_range(0, 149) == 0) begin
            do_reset();
         end else begin
            bus.btn_select = $urandom_range(0, 5) == 0;
            bus.btn_up     = $urandom_range(0, 3) == 0;
            bus.btn_down   = $urandom_range(0, 3) == 0;
            bus.btn_left   = $urandom_range(0, 3) == 0;
            bus.btn_right  = $urandom_range(0, 3) == 0;
            bus.check_done = $urandom_range(0, 3) == 0;
            bus.game_over  = $urandom_range(0, 7) == 0;
            cycle("rand");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
